// File: rtl/mux_n_sched.sv
// Registered N:1 channel multiplexer with per-channel valid/ready handshake.
// Selects one producer per cycle, either by fixed index or by round-robin scan.
module mux_n_sched #(
  parameter int unsigned N    = 7,
  parameter int unsigned W    = 1,
  parameter int unsigned SELW = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [SELW-1:0] rr_ptr;
  logic            free;
  logic            grant;
  logic [SELW-1:0] gidx;
  logic [W-1:0]    gdata;
  logic [SELW-1:0] rr_next;

  // Grant selection; round-robin scans [rr_ptr..N-1] first, then [0..rr_ptr-1].
  always_comb begin
    free     = ~out_valid | out_ready;
    grant    = 1'b0;
    gidx     = '0;
    gdata    = '0;
    in_ready = '0;
    if (!rst && free) begin
      if (!mode) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (SELW'(k) == sel && in_valid[k]) begin
            grant       = 1'b1;
            gidx        = SELW'(k);
            gdata       = in_data[k*W +: W];
            in_ready[k] = 1'b1;
          end
        end
      end else begin
        for (int unsigned k = 0; k < N; k++) begin
          if (!grant && k >= 32'(rr_ptr) && in_valid[k]) begin
            grant       = 1'b1;
            gidx        = SELW'(k);
            gdata       = in_data[k*W +: W];
            in_ready[k] = 1'b1;
          end
        end
        for (int unsigned k = 0; k < N; k++) begin
          if (!grant && k < 32'(rr_ptr) && in_valid[k]) begin
            grant       = 1'b1;
            gidx        = SELW'(k);
            gdata       = in_data[k*W +: W];
            in_ready[k] = 1'b1;
          end
        end
      end
    end
  end

  assign rr_next = (gidx == SELW'(N-1)) ? '0 : gidx + SELW'(1);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else if (free) begin
      if (grant) begin
        out_data  <= gdata;
        out_chan  <= gidx;
        out_valid <= 1'b1;
        if (mode) rr_ptr <= rr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
